// File: rtl/swan_pkg.sv
// Shared definitions for the SWAN serial datapath.
// Contents:
//   side_size / column_size : width derivations from the cipher block size
//   default_pa/pb/pc        : default theta column rotations per block size
//   NUM_COLUMNS             : columns per half-state word
//   swan_state_t            : IDLE / BUSY / DONE sequencing states
package swan_pkg;

    localparam int unsigned NUM_COLUMNS = 4;

    function automatic int unsigned side_size(input int unsigned block_size);
        return block_size / 2;
    endfunction

    function automatic int unsigned column_size(input int unsigned block_size);
        return block_size / 8;
    endfunction

    function automatic int unsigned default_pa(input int unsigned block_size);
        case (block_size)
            128:     return 1;
            256:     return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned default_pb(input int unsigned block_size);
        case (block_size)
            128:     return 3;
            256:     return 11;
            default: return 2;
        endcase
    endfunction

    function automatic int unsigned default_pc(input int unsigned block_size);
        case (block_size)
            128:     return 13;
            256:     return 27;
            default: return 7;
        endcase
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } swan_state_t;

endpackage

// File: rtl/theta_col.sv
// Single-column theta step, purely combinational.
// Ports:
//   v   : column of the half-state (MSB-first column, MSB at the left)
//   k   : matching round-key column
//   rot : rotation amount for this column (< COLUMN_SIZE)
//   inv : 0 = forward  y = rotr(v, rot) ^ k
//         1 = inverse  y = rotl(v ^ k, rot)
//   y   : resulting column
module theta_col #(
    parameter int unsigned COLUMN_SIZE = 8,
    parameter int unsigned ROT_W       = 3
) (
    input  logic [COLUMN_SIZE-1:0] v,
    input  logic [COLUMN_SIZE-1:0] k,
    input  logic [ROT_W-1:0]       rot,
    input  logic                   inv,
    output logic [COLUMN_SIZE-1:0] y
);

    logic [COLUMN_SIZE-1:0] vk;
    logic [COLUMN_SIZE-1:0] fwd_y;
    logic [COLUMN_SIZE-1:0] inv_y;

    // A shift by the full column width yields zero, so rot = 0 degenerates
    // cleanly to the identity rotation.
    always_comb begin
        vk    = v ^ k;
        fwd_y = ((v >> rot) | (v << (COLUMN_SIZE - 32'(rot)))) ^ k;
        inv_y = (vk << rot) | (vk >> (COLUMN_SIZE - 32'(rot)));
        y     = inv ? inv_y : fwd_y;
    end

endmodule

// File: rtl/theta_key_stream.sv
// Sequential theta-plus-round-key unit for the SWAN serial datapath.
// A half-state word and round key are latched on accept, then LANES columns
// per cycle are rotated and key-mixed into the y register. The result is
// presented with a valid/ready handshake and held until consumed.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : input handshake for x, rk, inv
//   x, rk               : half-state and round key, column 0 in the MSBs
//   inv                 : 0 = forward (encrypt), 1 = inverse (decrypt)
//   out_valid/out_ready : output handshake for y
//   y                   : result, defined while out_valid is high
module theta_key_stream
    import swan_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = 64,
    parameter int unsigned PA         = default_pa(BLOCK_SIZE),
    parameter int unsigned PB         = default_pb(BLOCK_SIZE),
    parameter int unsigned PC         = default_pc(BLOCK_SIZE),
    parameter int unsigned LANES      = 1,
    localparam int unsigned SIDE_SIZE   = side_size(BLOCK_SIZE),
    localparam int unsigned COLUMN_SIZE = column_size(BLOCK_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIDE_SIZE-1:0] x,
    input  logic [SIDE_SIZE-1:0] rk,
    input  logic                 inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIDE_SIZE-1:0] y
);

    localparam int unsigned ROT_W     = $clog2(COLUMN_SIZE);
    localparam logic [1:0]  STEP      = 2'(LANES);
    localparam logic [1:0]  LAST_BASE = 2'(NUM_COLUMNS - LANES);

    swan_state_t state, state_next;

    logic [1:0]                   col_cnt;
    logic [SIDE_SIZE-1:0]         x_q;
    logic [SIDE_SIZE-1:0]         rk_q;
    logic                         inv_q;
    logic [SIDE_SIZE-1:0]         y_q;
    logic [SIDE_SIZE-1:0]         y_next;
    logic [LANES*COLUMN_SIZE-1:0] lane_y_flat;
    logic                         accept;
    logic                         last_col;

    function automatic logic [COLUMN_SIZE-1:0] column_of(
        input logic [SIDE_SIZE-1:0] v,
        input logic [1:0]           idx
    );
        return v[SIDE_SIZE-1 - 32'(idx)*COLUMN_SIZE -: COLUMN_SIZE];
    endfunction

    function automatic logic [ROT_W-1:0] rot_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return ROT_W'(PC);
            2'd1:    return ROT_W'(PB);
            2'd2:    return ROT_W'(PA);
            default: return '0;
        endcase
    endfunction

    // Each lane handles column col_cnt + l; the 2-bit sum wraps modulo 4.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [1:0] idx;
        assign idx = col_cnt + 2'(l);

        theta_col #(
            .COLUMN_SIZE(COLUMN_SIZE),
            .ROT_W      (ROT_W)
        ) u_col (
            .v  (column_of(x_q, idx)),
            .k  (column_of(rk_q, idx)),
            .rot(rot_of(idx)),
            .inv(inv_q),
            .y  (lane_y_flat[l*COLUMN_SIZE +: COLUMN_SIZE])
        );
    end

    // Columns outside the current lane window keep their previous value.
    always_comb begin
        logic [1:0] sel;
        sel    = '0;
        y_next = y_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            sel = col_cnt + 2'(l);
            y_next[SIDE_SIZE-1 - 32'(sel)*COLUMN_SIZE -: COLUMN_SIZE] =
                lane_y_flat[l*COLUMN_SIZE +: COLUMN_SIZE];
        end
    end

    assign last_col = (col_cnt == LAST_BASE);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last_col) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready   = 1'b1;
                    state_next = in_valid ? BUSY : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign y      = y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            rk_q    <= '0;
            inv_q   <= 1'b0;
            y_q     <= '0;
            col_cnt <= '0;
        end else if (accept) begin
            x_q     <= x;
            rk_q    <= rk;
            inv_q   <= inv;
            col_cnt <= '0;
        end else if (state == BUSY) begin
            y_q     <= y_next;
            col_cnt <= col_cnt + STEP;
        end
    end

endmodule

// File: tb/tb_theta_key_stream.sv
module tb_theta_key_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit done [6];

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Six configurations: BLOCK_SIZE {64,128} x LANES {1,2,4}
    for (genvar g = 0; g < 6; g++) begin : g_cfg
        localparam int G    = g;
        localparam int unsigned BS   = (g < 3) ? 64 : 128;
        localparam int unsigned LN   = 1 << (g % 3);
        localparam int unsigned SIDE = BS / 2;
        localparam int unsigned C    = SIDE / 4;
        localparam int unsigned P_A  = 1;
        localparam int unsigned P_B  = (BS == 64) ? 2 : 3;
        localparam int unsigned P_C  = (BS == 64) ? 7 : 13;
        localparam int LAT = 4 / LN;

        logic rst_n, in_valid, in_ready, inv, out_valid, out_ready;
        logic [SIDE-1:0] x, rk, y;

        logic [SIDE-1:0] exp_q[$];
        int              acc_q[$];

        theta_key_stream #(
            .BLOCK_SIZE(BS),
            .PA        (P_A),
            .PB        (P_B),
            .PC        (P_C),
            .LANES     (LN)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .x        (x),
            .rk       (rk),
            .inv      (inv),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .y        (y)
        );

        // Reference: split into four integer columns, rotate with shifts.
        function automatic logic [SIDE-1:0] model(input logic [SIDE-1:0] xv,
                                                  input logic [SIDE-1:0] rv,
                                                  input logic iv);
            logic [SIDE-1:0] res = '0;
            longint unsigned mask = (64'd1 << C) - 1;
            for (int i = 0; i < 4; i++) begin
                int sh = SIDE - C * (i + 1);
                int p  = (i == 0) ? P_C : (i == 1) ? P_B : (i == 2) ? P_A : 0;
                longint unsigned cx = (64'(xv) >> sh) & mask;
                longint unsigned ck = (64'(rv) >> sh) & mask;
                longint unsigned c, m;
                if (!iv) begin
                    c = (((cx >> p) | (cx << (C - p))) & mask) ^ ck;
                end else begin
                    m = cx ^ ck;
                    c = ((m << p) | (m >> (C - p))) & mask;
                end
                res = res | (SIDE'(c) << sh);
            end
            return res;
        endfunction

        function automatic logic [SIDE-1:0] rnd_word();
            logic [63:0] w = {$urandom(), $urandom()};
            return w[SIDE-1:0];
        endfunction

        // Called just after a rising edge; returns just after the accept edge.
        task automatic send(input logic [SIDE-1:0] xv, input logic [SIDE-1:0] rv,
                            input logic iv, input logic [SIDE-1:0] e,
                            input bit rnd, output int waited);
            int n   = 0;
            bit acc = 1'b0;
            exp_q.push_back(e);
            x = xv; rk = rv; inv = iv; in_valid = 1'b1;
            while (!acc && n < 64) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                n++;
                if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            end
            check(acc, $sformatf("cfg%0d_accept_timeout", G), 128'(acc), 1);
            in_valid = 1'b0;
            x = rnd_word(); rk = rnd_word(); inv = 1'($urandom());
            waited = n;
        endtask

        task automatic drain();
            int n = 0;
            out_ready = 1'b1;
            while (exp_q.size() > 0 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            check(exp_q.size() == 0, $sformatf("cfg%0d_drain", G), 128'(exp_q.size()), 0);
        endtask

        // Monitor / scoreboard
        initial begin : mon
            bit prev_ov = 1'b0;
            logic [SIDE-1:0] held = '0;
            logic [SIDE-1:0] e;
            int t;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev_ov = 1'b0;
                end else begin
                    if (in_valid && in_ready) acc_q.push_back(cyc + 1);
                    if (out_valid && !prev_ov) begin
                        if (exp_q.size() == 0 || acc_q.size() == 0) begin
                            check(1'b0, $sformatf("cfg%0d_unexpected_output", G), 128'(y), 0);
                        end else begin
                            e = exp_q.pop_front();
                            t = acc_q.pop_front();
                            check(y === e, $sformatf("cfg%0d_data", G), 128'(y), 128'(e));
                            check(cyc - t == LAT, $sformatf("cfg%0d_latency", G),
                                  128'(cyc - t), 128'(LAT));
                        end
                        held = y;
                    end else if (out_valid) begin
                        check(y === held, $sformatf("cfg%0d_hold", G), 128'(y), 128'(held));
                    end
                    if (out_valid && !out_ready)
                        check(!in_ready, $sformatf("cfg%0d_bp_in_ready", G), 128'(in_ready), 0);
                    prev_ov = out_valid;
                end
            end
        end

        // Driver
        initial begin : drv
            int w;
            logic [SIDE-1:0] xa, ra, f;
            logic [SIDE-1:0] pat80 = {(SIDE/8){8'h80}};
            logic [SIDE-1:0] dead  = {(SIDE/32){32'hDEADBEEF}};
            rst_n = 1'b0; in_valid = 1'b0; x = '0; rk = '0; inv = 1'b0; out_ready = 1'b1;
            @(posedge clk);
            #1;
            check(in_ready === 1'b1, $sformatf("cfg%0d_rst_in_ready", G), 128'(in_ready), 1);
            check(out_valid === 1'b0, $sformatf("cfg%0d_rst_out_valid", G), 128'(out_valid), 0);
            check(y === '0, $sformatf("cfg%0d_rst_y", G), 128'(y), 0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;

            // Directed vectors (known answers for the 64-bit block)
            send(pat80, '0, 1'b0,
                 (BS == 64) ? SIDE'(32'h01204080) : model(pat80, '0, 1'b0), 1'b0, w);
            send('0, dead, 1'b0, dead, 1'b0, w);
            send('0, dead, 1'b1,
                 (BS == 64) ? SIDE'(32'h6FB67DEF) : model('0, dead, 1'b1), 1'b0, w);
            drain();

            // Backpressure: hold the result, then release with a new word
            out_ready = 1'b0;
            xa = rnd_word(); ra = rnd_word();
            send(xa, ra, 1'b0, model(xa, ra, 1'b0), 1'b0, w);
            w = 0;
            while (!out_valid && w < 20) begin
                @(posedge clk);
                #1;
                w++;
            end
            repeat (10) @(posedge clk);
            #1;
            check(in_ready === 1'b0, $sformatf("cfg%0d_bp_hold_in_ready", G), 128'(in_ready), 0);
            out_ready = 1'b1;
            xa = rnd_word(); ra = rnd_word();
            send(xa, ra, 1'b1, model(xa, ra, 1'b1), 1'b0, w);
            check(w == 1, $sformatf("cfg%0d_same_cycle_accept", G), 128'(w), 1);
            drain();

            // Reset during the second BUSY cycle (the only one when LANES=4)
            xa = rnd_word(); ra = rnd_word();
            send(xa, ra, 1'b0, model(xa, ra, 1'b0), 1'b0, w);
            if (LN != 4) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check(out_valid === 1'b0, $sformatf("cfg%0d_midrst_out_valid", G), 128'(out_valid), 0);
            check(y === '0, $sformatf("cfg%0d_midrst_y", G), 128'(y), 0);
            check(in_ready === 1'b1, $sformatf("cfg%0d_midrst_in_ready", G), 128'(in_ready), 1);
            exp_q.delete();
            acc_q.delete();
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (8) @(posedge clk);
            #1;
            check(out_valid === 1'b0, $sformatf("cfg%0d_no_stale", G), 128'(out_valid), 0);
            xa = rnd_word(); ra = rnd_word();
            send(xa, ra, 1'b0, model(xa, ra, 1'b0), 1'b0, w);
            drain();

            // Random round trips under random backpressure
            for (int i = 0; i < 1000; i++) begin
                xa = rnd_word(); ra = rnd_word();
                f  = model(xa, ra, 1'b0);
                send(xa, ra, 1'b0, f, 1'b1, w);
                send(f, ra, 1'b1, xa, 1'b1, w);
            end
            drain();
            done[g] = 1'b1;
        end
    end

    initial begin : summary
        bit all = 1'b0;
        int n = 0;
        while (!all && n < 60000) begin
            @(posedge clk);
            n++;
            all = 1'b1;
            for (int i = 0; i < 6; i++) if (!done[i]) all = 1'b0;
        end
        check(all, "run_timeout", 128'(all), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
